// File: rtl/fp_mul_pipe_param_if.sv
// Operand/result handshake bundle for fp_mul_pipe_param.
// The master side drives operands and accepts results; the slave side is the multiplier.
interface fp_mul_pipe_param_if #(
  parameter int EW = 3,
  parameter int FW = 4
);
  localparam int W = 1 + EW + FW;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         ovf;
  logic         unf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y, ovf, unf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y, ovf, unf
  );
endinterface

// File: rtl/fp_mul_pipe_param.sv
// Multi-cycle {sign, biased exp, frac} multiplier with saturation/flush flags.
// Define FP_MUL_RNE_EN for round-to-nearest-even; otherwise the fraction is truncated.
module fp_mul_pipe_param #(
  parameter int EW = 3,
  parameter int FW = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  fp_mul_pipe_param_if.slave  io
);
  localparam int W  = 1 + EW + FW;
  localparam int PW = 2 * FW + 2;
  localparam int XW = EW + 2;

  localparam logic signed [XW-1:0] BIAS = XW'((1 << (EW - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EW) - 1);
  localparam logic signed [XW-1:0] EMIN = XW'(1);

`ifdef FP_MUL_RNE_EN
  localparam logic RNE_EN = 1'b1;
`else
  localparam logic RNE_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_NORM, S_RND, S_DONE} state_t;

  state_t state_q;
  logic   in_ready_q, out_valid_q;

  logic [W-1:0]           a_q, a_d, b_q, b_d;
  logic [PW-1:0]          prod_q, prod_d;
  logic signed [XW-1:0]   exp_q, exp_d;
  logic                   sign_q, sign_d, zero_q, zero_d;
  logic [FW-1:0]          mant_q, mant_d;
  logic                   guard_q, guard_d, sticky_q, sticky_d;
  logic [W-1:0]           y_q, y_d;
  logic                   ovf_q, ovf_d, unf_q, unf_d;

  logic                   accept;
  logic [PW-1:0]          ma_w, mb_w;
  logic signed [XW-1:0]   ea_w, eb_w, exp_rnd_w;
  logic [PW-2:0]          pn_w;
  logic [FW:0]            rnd_w;
  logic [W+1:0]           pack_w;

  function automatic logic [FW:0] round_frac(input logic [FW-1:0] m, input logic g,
                                             input logic st);
    logic inc;
    inc = RNE_EN & g & (st | m[0]);
    round_frac = {1'b0, m} + {{FW{1'b0}}, inc};
  endfunction

  // Result is {ovf, unf, y}.
  function automatic logic [W+1:0] pack(input logic s, input logic z,
                                        input logic signed [XW-1:0] e,
                                        input logic [FW-1:0] f);
    if (z)              pack = {2'b00, s, {(EW + FW){1'b0}}};
    else if (e > EMAX)  pack = {2'b10, s, {(EW + FW){1'b1}}};
    else if (e < EMIN)  pack = {2'b01, s, {(EW + FW){1'b0}}};
    else                pack = {2'b00, s, e[EW-1:0], f};
  endfunction

  assign accept    = io.in_valid & in_ready_q;
  assign ma_w      = PW'({1'b1, a_q[FW-1:0]});
  assign mb_w      = PW'({1'b1, b_q[FW-1:0]});
  assign ea_w      = $signed({2'b00, a_q[W-2 -: EW]});
  assign eb_w      = $signed({2'b00, b_q[W-2 -: EW]});
  // Left-align the product so the hidden 1 always sits just above the mantissa.
  assign pn_w      = prod_q[PW-1] ? prod_q[PW-2:0] : {prod_q[PW-3:0], 1'b0};
  assign rnd_w     = round_frac(mant_q, guard_q, sticky_q);
  assign exp_rnd_w = exp_q + $signed({{(XW - 1){1'b0}}, rnd_w[FW]});
  assign pack_w    = pack(sign_q, zero_q, exp_rnd_w, rnd_w[FW-1:0]);

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    mant_d   = mant_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    y_d      = y_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d = io.a;
          b_d = io.b;
        end
      end
      // MUL: full mantissa product and unnormalised exponent
      S_MUL: begin
        prod_d = ma_w * mb_w;
        exp_d  = ea_w + eb_w - BIAS;
        sign_d = a_q[W-1] ^ b_q[W-1];
        zero_d = (a_q[W-2 -: EW] == '0) | (b_q[W-2 -: EW] == '0);
      end
      // NORM: select mantissa, guard and sticky
      S_NORM: begin
        mant_d   = pn_w[PW-2 -: FW];
        guard_d  = pn_w[FW];
        sticky_d = |pn_w[FW-1:0];
        exp_d    = exp_q + $signed({{(XW - 1){1'b0}}, prod_q[PW-1]});
      end
      // RND: round, renormalise on carry, pack and saturate
      S_RND: begin
        y_d   = pack_w[W-1:0];
        unf_d = pack_w[W];
        ovf_d = pack_w[W+1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      y_q   <= y_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q    <= S_MUL;
            in_ready_q <= 1'b0;
          end
        end
        S_MUL:  state_q <= S_NORM;
        S_NORM: state_q <= S_RND;
        S_RND: begin
          state_q     <= S_DONE;
          out_valid_q <= 1'b1;
        end
        S_DONE: begin
          if (io.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    a_q      <= a_d;
    b_q      <= b_d;
    prod_q   <= prod_d;
    exp_q    <= exp_d;
    sign_q   <= sign_d;
    zero_q   <= zero_d;
    mant_q   <= mant_d;
    guard_q  <= guard_d;
    sticky_q <= sticky_d;
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.y         = y_q;
  assign io.ovf       = ovf_q;
  assign io.unf       = unf_q;
endmodule
